dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single-port data memory.
- Requester 0 is the processor control unit (its D_addr/D_wr/store-data path); requester 1 is the host/debug port used to preload and inspect data memory.
- Registered grant, round-robin fairness, and a bounded hold (lock) so the CPU's two-cycle Load_A/Load_B access is never split.
- Sits between the control unit/host port and the data RAM.

Parameters:
AW, 8, memory address width
DW, 16, memory data width
MAX_HOLD, 4, max consecutive granted cycles while the other requester waits (1..255)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
req0  in  1  requester 0 (CPU) access request; held high for the whole access
wr0  in  1  requester 0 write enable
addr0  in  AW  requester 0 address
wdata0  in  DW  requester 0 write data
gnt0  out  1  requester 0 owns memory this cycle
rvalid0  out  1  rdata valid for requester 0
req1, wr1, addr1, wdata1, gnt1, rvalid1  same as above for requester 1 (host)
rdata  out  DW  read data, broadcast; qualified by rvalidN
mem_addr  out  AW  to RAM
mem_wr  out  1  to RAM write enable
mem_wdata  out  DW  to RAM
mem_rdata  in  DW  from RAM, synchronous read, valid 1 cycle after address
busy  out  1  any grant active
owner  out  1  last/current owner index

Behaviour:
- Reset (async, while Reset=1): state IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, mem_wr=0, mem_addr=0, mem_wdata=0, busy=0, owner=1 (so requester 0 wins the first tie), hold counter=0.
- States:
  - IDLE: no owner.
  - OWN0 / OWN1: gntN=1, busy=1, owner=N.
- Grant is registered. If reqN is high at edge k, gntN can go high at the earliest after edge k (1-cycle latency).
- Arbitration at each edge from IDLE, or when the current owner releases:
  - Only one requester asserting reqN: grant it.
  - Both asserting: grant the one not equal to owner (round-robin).
- While in OWNn:
  - mem_addr=addrN, mem_wdata=wdataN, mem_wr=wrN & reqN. All combinational from the owner's inputs.
  - Non-owner inputs are ignored; writes from the non-owner never reach the RAM.
- Release: the owner drops reqN at cycle c. At edge end of c:
  - other requester requesting: go directly to OWN(other), zero bubble; gntN=0 and gnt(other)=1 in cycle c+1;
  - otherwise go to IDLE.
- Hold counter:
  - Cleared on every new grant; increments each granted cycle, saturating at MAX_HOLD.
  - When the counter equals MAX_HOLD, the owner is still requesting, and the other requester is requesting: forced handover to the other at the next edge.
  - The preempted requester keeps req high and regains the grant by round-robin later.
  - With no competing request, the owner holds indefinitely.
- Read return:
  - A granted cycle with wrN=0 produces rvalidN=1 exactly one cycle later, with rdata=mem_rdata.
  - Reads return in issue order. rvalid is tracked per issuing requester, so a read issued in the last owned cycle still returns to that requester after handover.
  - rdata=0 when neither rvalid is set.
- Writes: a granted cycle with wrN=1 writes at that edge; no rvalid is produced.
- Simultaneous events:
  - Owner release and the other's new request in the same cycle: zero-bubble handover.
  - Both requesting from IDLE immediately after reset: requester 0 wins.
- Reset mid-access: all grants and pending rvalids are dropped immediately (asynchronously). An in-flight read returns nothing.
- Deasserting reqN while not granted withdraws the request with no side effects.

Test Plan:
1. Reset release; req0=1 wr0=0 addr0=8'h10 at cycle 0 -> gnt0=1 in cycle 1, mem_addr=8'h10, rvalid0=1 in cycle 2 with rdata=RAM[8'h10].
2. req0 and req1 both rise in the same cycle from IDLE after reset -> gnt0 first. When req0 drops, gnt1 is asserted the next cycle with no IDLE cycle; gnt0 and gnt1 are never high together.
3. CPU load held two cycles (req0=1 for 2 cycles) while req1=1 throughout, MAX_HOLD=4 -> gnt0 stays 2 cycles unbroken, then gnt1; mem_addr never changes mid-load.
4. req0 held 10 cycles with req1 continuously high, MAX_HOLD=4 -> gnt0 for exactly 4 cycles, forced switch to gnt1, then back to gnt0 after req1 drops.
5. Requester 1 writes 16'hBEEF to 8'h20 while requester 0 drives wr0=1 addr0=8'h20 wdata0=16'h1234 ungranted -> RAM[8'h20]=16'hBEEF; a later read by requester 0 returns 16'hBEEF.
6. Assert Reset asynchronously mid-read (between grant and return) -> gnt0, rvalid0 and mem_wr go to 0 immediately, no rvalid after release, and requester 0 wins the next tie.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: registered round-robin grant with a bounded
// hold, combinational steering of the owner's access onto the RAM, per-requester read return.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          req0,
  input  logic          wr0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          wr1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic [7:0] hold_q, hold_d;
  logic       rv0_q, rv0_d;
  logic       rv1_q, rv1_d;

  logic       take;
  logic       take_idx;
  logic [7:0] hold_inc;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
      hold_q  <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    hold_d   = hold_q;
    take     = 1'b0;
    take_idx = 1'b0;
    hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + 8'd1;
    // A read is only issued while the owner still asserts its request.
    rv0_d    = (state_q == OWN0) && req0 && !wr0;
    rv1_d    = (state_q == OWN1) && req1 && !wr1;

    case (state_q)
      IDLE: begin
        if (req0 && (!req1 || owner_q)) begin
          take = 1'b1; take_idx = 1'b0;
        end else if (req1) begin
          take = 1'b1; take_idx = 1'b1;
        end
      end
      OWN0: begin
        if (!req0) begin
          if (req1) begin take = 1'b1; take_idx = 1'b1; end
          else state_d = IDLE;
        end else if (req1 && hold_inc == HOLD_MAX) begin
          take = 1'b1; take_idx = 1'b1;
        end else begin
          hold_d = hold_inc;
        end
      end
      OWN1: begin
        if (!req1) begin
          if (req0) begin take = 1'b1; take_idx = 1'b0; end
          else state_d = IDLE;
        end else if (req0 && hold_inc == HOLD_MAX) begin
          take = 1'b1; take_idx = 1'b0;
        end else begin
          hold_d = hold_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      state_d = take_idx ? OWN1 : OWN0;
      owner_d = take_idx;
      hold_d  = '0;
    end
  end

  always_comb begin
    gnt0      = (state_q == OWN0);
    gnt1      = (state_q == OWN1);
    busy      = (state_q != IDLE);
    owner     = owner_q;
    rvalid0   = rv0_q;
    rvalid1   = rv1_q;
    rdata     = (rv0_q || rv1_q) ? mem_rdata : '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr    = 1'b0;
    case (state_q)
      OWN0: begin
        mem_addr  = addr0;
        mem_wdata = wdata0;
        mem_wr    = wr0 & req0;
      end
      OWN1: begin
        mem_addr  = addr1;
        mem_wdata = wdata1;
        mem_wr    = wr1 & req1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked every
// cycle against an ownership/queue model of the arbitration rules.
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MAXH = 4;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic req0 = 0, wr0 = 0, req1 = 0, wr1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_wr, busy, owner;
  logic [DW-1:0] rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAXH)) dut (
    .Clk(Clk), .Reset(Reset),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 Clk = ~Clk;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return 16'hA000 | {8'h00, a};
  endfunction

  // Synchronous-read RAM seen by the DUT
  bit [DW-1:0] ram [256];
  bit          ram_w [256];
  always @(posedge Clk) begin
    if (mem_wr) begin
      ram[mem_addr]   <= mem_wdata;
      ram_w[mem_addr] <= 1'b1;
    end
    mem_rdata <= ram_w[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
  end

  // Reference model: who owns memory, how long, and what reads are in flight
  int          cur = -1;
  int          last = 1;
  int          run = 0;
  bit          pv0 = 0, pv1 = 0;
  logic [DW-1:0] pdata = '0;
  bit [DW-1:0] gmem [256];
  bit          gw [256];

  function automatic logic [DW-1:0] gread(input logic [AW-1:0] a);
    return gw[a] ? gmem[a] : init_val(a);
  endfunction

  always @(posedge Clk or posedge Reset) begin : mdl
    int  nxt;
    bit  mine, theirs;
    if (Reset) begin
      cur <= -1; last <= 1; run <= 0; pv0 <= 0; pv1 <= 0; pdata <= '0;
    end else begin
      pv0 <= (cur == 0) && req0 && !wr0;
      pv1 <= (cur == 1) && req1 && !wr1;
      if (cur == 0 && req0 && !wr0) pdata <= gread(addr0);
      else if (cur == 1 && req1 && !wr1) pdata <= gread(addr1);
      if (cur == 0 && req0 && wr0) begin gmem[addr0] <= wdata0; gw[addr0] <= 1; end
      if (cur == 1 && req1 && wr1) begin gmem[addr1] <= wdata1; gw[addr1] <= 1; end
      if (cur < 0) begin
        if (req0 && req1) nxt = 1 - last;
        else if (req0)    nxt = 0;
        else if (req1)    nxt = 1;
        else              nxt = -1;
      end else begin
        mine   = (cur == 0) ? req0 : req1;
        theirs = (cur == 0) ? req1 : req0;
        if (!mine)                           nxt = theirs ? 1 - cur : -1;
        else if (theirs && run + 1 >= MAXH)  nxt = 1 - cur;
        else                                 nxt = cur;
      end
      cur <= nxt;
      if (nxt >= 0 && nxt != cur) begin last <= nxt; run <= 0; end
      else if (nxt >= 0)           run <= run + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew;
    ea = '0; ed = '0; ew = 1'b0;
    if (cur == 0)      begin ea = addr0; ed = wdata0; ew = req0 & wr0; end
    else if (cur == 1) begin ea = addr1; ed = wdata1; ew = req1 & wr1; end
    check("gnt0",      32'(gnt0),      32'(cur == 0));
    check("gnt1",      32'(gnt1),      32'(cur == 1));
    check("busy",      32'(busy),      32'(cur >= 0));
    check("owner",     32'(owner),     32'(last[0]));
    check("mem_addr",  32'(mem_addr),  32'(ea));
    check("mem_wdata", 32'(mem_wdata), 32'(ed));
    check("mem_wr",    32'(mem_wr),    32'(ew));
    check("rvalid0",   32'(rvalid0),   32'(pv0));
    check("rvalid1",   32'(rvalid1),   32'(pv1));
    check("rdata",     32'(rdata),     32'((pv0 || pv1) ? pdata : '0));
  endtask

  task automatic tick();
    @(negedge Clk);
    compare_all();
    @(posedge Clk);
    #1;
  endtask

  task automatic drop_all();
    req0 = 0; wr0 = 0; req1 = 0; wr1 = 0;
  endtask

  task automatic idle();
    drop_all();
    repeat (3) tick();
  endtask

  task automatic do_reset();
    drop_all();
    Reset = 1;
    @(posedge Clk);
    #1;
    Reset = 0;
  endtask

  bit g0 [16];
  bit g1 [16];

  initial begin
    int n0, bad, k;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_gnt0",   32'(gnt0),     32'd0);
    check("rst_gnt1",   32'(gnt1),     32'd0);
    check("rst_busy",   32'(busy),     32'd0);
    check("rst_owner",  32'(owner),    32'd1);
    check("rst_addr",   32'(mem_addr), 32'd0);
    check("rst_mem_wr", 32'(mem_wr),   32'd0);
    check("rst_rdata",  32'(rdata),    32'd0);
    Reset = 0;

    // single CPU read
    req0 = 1; addr0 = 8'h10;
    tick();
    check("t1_gnt0", 32'(gnt0), 32'd1);
    check("t1_addr", 32'(mem_addr), 32'h10);
    tick();
    check("t1_rvalid0", 32'(rvalid0), 32'd1);
    check("t1_rdata",   32'(rdata),   32'hA010);
    idle();

    // tie after reset, then zero-bubble handover
    do_reset();
    req0 = 1; req1 = 1; addr0 = 8'h01; addr1 = 8'h02;
    tick();
    check("t2_first_gnt0", 32'(gnt0), 32'd1);
    check("t2_first_gnt1", 32'(gnt1), 32'd0);
    tick();
    req0 = 0;
    tick();
    check("t2_handover_gnt1", 32'(gnt1), 32'd1);
    check("t2_handover_gnt0", 32'(gnt0), 32'd0);
    idle();

    // two-cycle CPU load is not split by a waiting host
    do_reset();
    req0 = 1; req1 = 1; addr0 = 8'h30; addr1 = 8'h31;
    n0 = 0; bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (gnt0) begin n0++; if (mem_addr != 8'h30) bad++; end
      if (i == 1) req0 = 0;
    end
    check("t3_gnt0_len",     32'(n0),  32'd2);
    check("t3_addr_stable",  32'(bad), 32'd0);
    idle();

    // hold limit forces handover, then the CPU returns
    do_reset();
    req0 = 1; req1 = 1; addr0 = 8'h40; addr1 = 8'h41;
    for (int i = 0; i < 16; i++) begin
      tick();
      g0[i] = gnt0; g1[i] = gnt1;
      if (i == 6) req1 = 0;
      if (i == 9) req0 = 0;
    end
    k = 0;
    while (k < 16 && g0[k]) k++;
    check("t4_gnt0_run",    32'(k),     32'd4);
    check("t4_forced_gnt1", 32'(g1[4]), 32'd1);
    check("t4_back_gnt0",   32'(g0[7]), 32'd1);
    idle();

    // host write wins; ungranted CPU write is ignored
    req1 = 1; wr1 = 1; addr1 = 8'h20; wdata1 = 16'hBEEF;
    tick();
    check("t5_gnt1", 32'(gnt1), 32'd1);
    req0 = 1; wr0 = 1; addr0 = 8'h20; wdata0 = 16'h1234;
    tick();
    drop_all();
    tick(); tick();
    check("t5_ram", 32'(ram_w[8'h20] ? ram[8'h20] : init_val(8'h20)), 32'hBEEF);
    req0 = 1; wr0 = 0; addr0 = 8'h20;
    tick(); tick();
    check("t5_rvalid0", 32'(rvalid0), 32'd1);
    check("t5_rdata",   32'(rdata),   32'hBEEF);
    idle();

    // async reset while a read is in flight
    do_reset();
    req0 = 1; req1 = 1; addr0 = 8'h10; addr1 = 8'h11;
    tick();
    tick();
    check("t6_rv_before", 32'(rvalid0), 32'd1);
    #2 Reset = 1;
    #1;
    check("t6_gnt0",    32'(gnt0),    32'd0);
    check("t6_rvalid0", 32'(rvalid0), 32'd0);
    check("t6_mem_wr",  32'(mem_wr),  32'd0);
    check("t6_rdata",   32'(rdata),   32'd0);
    check("t6_owner",   32'(owner),   32'd1);
    @(posedge Clk);
    #1;
    Reset = 0;
    check("t6_no_rvalid", 32'(rvalid0), 32'd0);
    tick();
    check("t6_tie_gnt0",   32'(gnt0),    32'd1);
    check("t6_tie_rvalid", 32'(rvalid0), 32'd0);
    idle();

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if (!req0) begin if ($urandom_range(3) == 0) req0 = 1; end
      else if ($urandom_range(4) == 0) req0 = 0;
      if (!req1) begin if ($urandom_range(3) == 0) req1 = 1; end
      else if ($urandom_range(4) == 0) req1 = 0;
      if ($urandom_range(1) == 1) begin
        wr0 = ($urandom_range(2) == 0); addr0 = 8'($urandom_range(15)); wdata0 = 16'($urandom);
      end
      if ($urandom_range(1) == 1) begin
        wr1 = ($urandom_range(2) == 0); addr1 = 8'($urandom_range(15)); wdata1 = 16'($urandom);
      end
      tick();
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
